// File: rtl/fft_sched_pkg.sv
// Shared constants, phase encodings and FSM state type for the 32-point FFT stage scheduler.
package fft_sched_pkg;

  localparam int N       = 32;
  localparam int LOG2N   = 5;
  localparam int BATCHES = 4;
  localparam int ADDR_W  = LOG2N;

  localparam logic [2:0] PH_MUL1 = 3'd0;
  localparam logic [2:0] PH_MUL2 = 3'd1;
  localparam logic [2:0] PH_MUL3 = 3'd2;
  localparam logic [2:0] PH_MUL4 = 3'd3;
  localparam logic [2:0] PH_IDLE = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    RUN,
    BUBBLE,
    DRAIN,
    DONE
  } sched_state_e;

endpackage

// File: rtl/fft_stage_scheduler_if.sv
// Control/address bus between the FFT stage scheduler and its host/memory side.
// Optional FFT_SCHED_IFFT_EN adds i_inverse / o_twConj.
interface fft_stage_scheduler_if;
  logic        i_start;
  logic        o_busy;
  logic        o_done;
  logic [2:0]  o_phase;
  logic        o_rdEn;
  logic [4:0]  o_rdAddrTop;
  logic [4:0]  o_rdAddrBot;
  logic [3:0]  o_twIdx;
  logic [3:0]  o_stageLoad;
  logic        o_wrEn;
  logic [39:0] o_wrAddr;
`ifdef FFT_SCHED_IFFT_EN
  logic        i_inverse;
  logic        o_twConj;

  modport master (
    output i_start, i_inverse,
    input  o_busy, o_done, o_phase, o_rdEn, o_rdAddrTop, o_rdAddrBot,
           o_twIdx, o_stageLoad, o_wrEn, o_wrAddr, o_twConj
  );
  modport slave (
    input  i_start, i_inverse,
    output o_busy, o_done, o_phase, o_rdEn, o_rdAddrTop, o_rdAddrBot,
           o_twIdx, o_stageLoad, o_wrEn, o_wrAddr, o_twConj
  );
`else
  modport master (
    output i_start,
    input  o_busy, o_done, o_phase, o_rdEn, o_rdAddrTop, o_rdAddrBot,
           o_twIdx, o_stageLoad, o_wrEn, o_wrAddr
  );
  modport slave (
    input  i_start,
    output o_busy, o_done, o_phase, o_rdEn, o_rdAddrTop, o_rdAddrBot,
           o_twIdx, o_stageLoad, o_wrEn, o_wrAddr
  );
`endif
endinterface

// File: rtl/fft_bf_addr_gen.sv
// Radix-2 DIT butterfly operand addresses and twiddle index for a given stage and butterfly.
module fft_bf_addr_gen
  import fft_sched_pkg::*;
(
  input  logic [2:0]        stage_i,
  input  logic [3:0]        bf_idx_i,
  output logic [ADDR_W-1:0] top_o,
  output logic [ADDR_W-1:0] bot_o,
  output logic [3:0]        tw_o
);

  logic [ADDR_W-1:0] idx_ext;
  logic [ADDR_W-1:0] half;
  logic [ADDR_W-1:0] mask;

  always_comb begin
    idx_ext = {1'b0, bf_idx_i};
    half    = ADDR_W'(1) << stage_i;
    mask    = half - ADDR_W'(1);
    // Group base is (j >> s) * 2 * half; offset within the group is j mod half.
    top_o   = ((idx_ext >> stage_i) << (stage_i + 3'd1)) | (idx_ext & mask);
    bot_o   = top_o + half;
    tw_o    = (bf_idx_i & mask[3:0]) << (3'd4 - stage_i);
  end

endmodule

// File: rtl/fft_stage_scheduler.sv
// Sequences reads, staging loads and write-backs of a 32-point radix-2 FFT around a 5-phase shared multiplier.
// Optional FFT_SCHED_IFFT_EN adds inverse-transform twiddle conjugation control.
module fft_stage_scheduler
  import fft_sched_pkg::*;
#(
  parameter int p_inputWidth    = 8,
  parameter int p_PointPosition = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  fft_stage_scheduler_if.slave  bus
);

  if (p_PointPosition >= p_inputWidth) begin : g_bad_fixed_point
    $error("p_PointPosition must be smaller than p_inputWidth");
  end

  sched_state_e      state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic [2:0]        stage_q, stage_d;
  logic [1:0]        batch_q, batch_d;
  logic [3:0]        stage_load_q, stage_load_d;
  logic              col_vld_q, pend_vld_q;
  logic [9:0]        col_q [4];
  logic [39:0]       pend_addr_q;

  logic              rd_en, wr_en, win_end;
  logic [3:0]        bf_idx;
  logic [ADDR_W-1:0] top, bot;
  logic [3:0]        tw;

  fft_bf_addr_gen u_addr_gen (
    .stage_i  (stage_q),
    .bf_idx_i (bf_idx),
    .top_o    (top),
    .bot_o    (bot),
    .tw_o     (tw)
  );

  assign win_end      = (phase_q == PH_IDLE);
  assign phase_d      = win_end ? PH_MUL1 : phase_q + 3'd1;
  assign rd_en        = (state_q == RUN) && !win_end;
  assign bf_idx       = {batch_q, phase_q[1:0]};
  assign wr_en        = win_end && pend_vld_q;
  assign stage_load_d = rd_en ? (4'b0001 << phase_q[1:0]) : 4'b0000;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    batch_d = batch_q;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = ALIGN;
          stage_d = 3'd0;
          batch_d = 2'd0;
        end
      end
      ALIGN:  if (win_end) state_d = RUN;
      RUN: begin
        if (win_end) begin
          if (batch_q == 2'(BATCHES - 1)) begin
            batch_d = 2'd0;
            if (stage_q == 3'(LOG2N - 1)) begin
              state_d = DRAIN;
            end else begin
              // Next stage reads what this batch writes back at the end of the bubble.
              state_d = BUBBLE;
              stage_d = stage_q + 3'd1;
            end
          end else begin
            batch_d = batch_q + 2'd1;
          end
        end
      end
      BUBBLE: if (win_end) state_d = RUN;
      DRAIN:  if (win_end) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      phase_q      <= PH_IDLE;
      stage_q      <= 3'd0;
      batch_q      <= 2'd0;
      stage_load_q <= 4'b0000;
      col_vld_q    <= 1'b0;
      pend_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      stage_q      <= stage_d;
      batch_q      <= batch_d;
      stage_load_q <= stage_load_d;
      if (rd_en) begin
        col_vld_q <= 1'b1;
      end else if (win_end) begin
        // A batch read in this window is written back at the end of the next one.
        col_vld_q  <= 1'b0;
        pend_vld_q <= col_vld_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rd_en) col_q[phase_q[1:0]] <= {top, bot};
    if (win_end) pend_addr_q <= {col_q[0], col_q[1], col_q[2], col_q[3]};
  end

`ifdef FFT_SCHED_IFFT_EN
  logic inverse_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      inverse_q <= 1'b0;
    end else if (state_q == IDLE && bus.i_start) begin
      inverse_q <= bus.i_inverse;
    end
  end

  assign bus.o_twConj = inverse_q;
`endif

  assign bus.o_busy      = (state_q == ALIGN) || (state_q == RUN) ||
                           (state_q == BUBBLE) || (state_q == DRAIN);
  assign bus.o_done      = (state_q == DONE);
  assign bus.o_phase     = phase_q;
  assign bus.o_rdEn      = rd_en;
  assign bus.o_rdAddrTop = rd_en ? top : '0;
  assign bus.o_rdAddrBot = rd_en ? bot : '0;
  assign bus.o_twIdx     = rd_en ? tw : 4'd0;
  assign bus.o_stageLoad = stage_load_q;
  assign bus.o_wrEn      = wr_en;
  assign bus.o_wrAddr    = wr_en ? pend_addr_q : 40'd0;

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Directed bench for fft_stage_scheduler: reset, start alignment, address mapping, bubbles, full run and mid-run reset.
module tb_fft_stage_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fft_stage_scheduler_if bus();

  fft_stage_scheduler #(
    .p_inputWidth    (8),
    .p_PointPosition (3)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  localparam int CAP = 140;
  logic        cap_rd   [CAP];
  logic [4:0]  cap_top  [CAP];
  logic [4:0]  cap_bot  [CAP];
  logic [3:0]  cap_tw   [CAP];
  logic [3:0]  cap_sl   [CAP];
  logic        cap_wr   [CAP];
  logic [39:0] cap_wa   [CAP];
  logic        cap_done [CAP];
  logic        cap_busy [CAP];

  function automatic logic [61:0] outs_vec();
    return {bus.o_busy, bus.o_done, bus.o_rdEn, bus.o_rdAddrTop, bus.o_rdAddrBot,
            bus.o_twIdx, bus.o_stageLoad, bus.o_wrEn, bus.o_wrAddr};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.i_start = 1'b0;
`ifdef FFT_SCHED_IFFT_EN
    bus.i_inverse = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.o_phase !== 3'd4) begin
      errors++;
      $display("FAIL reset_phase: got %0d expected 4", bus.o_phase);
    end
    checks++;
    if (outs_vec() !== 62'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs_vec());
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus.o_phase !== 3'(i % 5)) begin
        errors++;
        $display("FAIL phase_seq[%0d]: got %0d expected %0d", i, bus.o_phase, i % 5);
      end
    end
  endtask

  task automatic test_start_align();
    int guard = 0;
    while (bus.o_phase !== 3'd2 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (bus.o_phase !== 3'd2) begin
      errors++;
      $display("FAIL wait_phase2: got %0d expected 2", bus.o_phase);
    end
    bus.i_start = 1'b1;
`ifdef FFT_SCHED_IFFT_EN
    bus.i_inverse = 1'b1;
`endif
    @(negedge clk);
    bus.i_start = 1'b0;
`ifdef FFT_SCHED_IFFT_EN
    bus.i_inverse = 1'b0;
    checks++;
    if (bus.o_twConj !== 1'b1) begin
      errors++;
      $display("FAIL twconj: got %0b expected 1", bus.o_twConj);
    end
`endif
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_rdEn !== 1'b0) begin
      errors++;
      $display("FAIL start_busy: got busy=%0b rd=%0b expected busy=1 rd=0", bus.o_busy, bus.o_rdEn);
    end
    @(negedge clk);
    checks++;
    if (bus.o_rdEn !== 1'b0) begin
      errors++;
      $display("FAIL align_no_read: got rd=%0b expected 0", bus.o_rdEn);
    end
    @(negedge clk);
    checks++;
    if ({bus.o_rdEn, bus.o_rdAddrTop, bus.o_rdAddrBot, bus.o_twIdx} !== {1'b1, 5'd0, 5'd1, 4'd0}) begin
      errors++;
      $display("FAIL first_read: got rd=%0b top=%0d bot=%0d tw=%0d expected 1/0/1/0",
               bus.o_rdEn, bus.o_rdAddrTop, bus.o_rdAddrBot, bus.o_twIdx);
    end
  endtask

  // Records the run from the first read (index 0); raises i_start for one cycle at inject_at.
  task automatic capture_run(input int inject_at);
    for (int c = 0; c < CAP; c++) begin
      cap_rd[c]   = bus.o_rdEn;
      cap_top[c]  = bus.o_rdAddrTop;
      cap_bot[c]  = bus.o_rdAddrBot;
      cap_tw[c]   = bus.o_twIdx;
      cap_sl[c]   = bus.o_stageLoad;
      cap_wr[c]   = bus.o_wrEn;
      cap_wa[c]   = bus.o_wrAddr;
      cap_done[c] = bus.o_done;
      cap_busy[c] = bus.o_busy;
      bus.i_start = (c == inject_at);
      @(negedge clk);
    end
    bus.i_start = 1'b0;
  endtask

  task automatic test_addresses();
    checks++;
    if ({cap_rd[56], cap_top[56], cap_bot[56], cap_tw[56]} !== {1'b1, 5'd9, 5'd13, 4'd4}) begin
      errors++;
      $display("FAIL s2_j5: got rd=%0b top=%0d bot=%0d tw=%0d expected 1/9/13/4",
               cap_rd[56], cap_top[56], cap_bot[56], cap_tw[56]);
    end
    checks++;
    if ({cap_rd[118], cap_top[118], cap_bot[118], cap_tw[118]} !== {1'b1, 5'd15, 5'd31, 4'd15}) begin
      errors++;
      $display("FAIL s4_j15: got rd=%0b top=%0d bot=%0d tw=%0d expected 1/15/31/15",
               cap_rd[118], cap_top[118], cap_bot[118], cap_tw[118]);
    end
    checks++;
    if (cap_sl[57] !== 4'b0010) begin
      errors++;
      $display("FAIL stage_load_slot2: got %b expected 0010", cap_sl[57]);
    end
    checks++;
    if (cap_sl[59] !== 4'b1000) begin
      errors++;
      $display("FAIL stage_load_slot4: got %b expected 1000", cap_sl[59]);
    end
  endtask

  task automatic test_bubble();
    logic [39:0] exp_b0, exp_b3;
    int          rd_in_bubble = 0;
    exp_b0 = {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
    exp_b3 = {5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31};
    for (int c = 20; c < 25; c++) rd_in_bubble += int'(cap_rd[c]);
    checks++;
    if (rd_in_bubble != 0) begin
      errors++;
      $display("FAIL bubble_reads: got %0d expected 0", rd_in_bubble);
    end
    checks++;
    if (cap_wr[9] !== 1'b1 || cap_wa[9] !== exp_b0) begin
      errors++;
      $display("FAIL wr_s0_b0: got wr=%0b addr=%h expected 1/%h", cap_wr[9], cap_wa[9], exp_b0);
    end
    checks++;
    if (cap_wr[24] !== 1'b1 || cap_wa[24] !== exp_b3) begin
      errors++;
      $display("FAIL wr_s0_b3: got wr=%0b addr=%h expected 1/%h", cap_wr[24], cap_wa[24], exp_b3);
    end
    checks++;
    if ({cap_wa[23], cap_top[24], cap_bot[24], cap_tw[24], cap_sl[23]} !== 58'd0) begin
      errors++;
      $display("FAIL idle_zero: got wa=%h top=%0d bot=%0d tw=%0d sl=%b expected all 0",
               cap_wa[23], cap_top[24], cap_bot[24], cap_tw[24], cap_sl[23]);
    end
  endtask

  task automatic test_full_run();
    int n_rd = 0, n_wr = 0, n_done = 0;
    logic [39:0] exp_last;
    exp_last = {5'd12, 5'd28, 5'd13, 5'd29, 5'd14, 5'd30, 5'd15, 5'd31};
    for (int c = 0; c < CAP; c++) begin
      n_rd   += int'(cap_rd[c]);
      n_wr   += int'(cap_wr[c]);
      n_done += int'(cap_done[c]);
    end
    checks++;
    if (n_rd != 80) begin
      errors++;
      $display("FAIL rd_count: got %0d expected 80", n_rd);
    end
    checks++;
    if (n_wr != 20) begin
      errors++;
      $display("FAIL wr_count: got %0d expected 20", n_wr);
    end
    checks++;
    if (n_done != 1 || cap_done[125] !== 1'b1) begin
      errors++;
      $display("FAIL done_timing: got count=%0d done@125=%0b expected 1/1", n_done, cap_done[125]);
    end
    checks++;
    if (cap_wr[124] !== 1'b1 || cap_wa[124] !== exp_last) begin
      errors++;
      $display("FAIL last_write: got wr=%0b addr=%h expected 1/%h", cap_wr[124], cap_wa[124], exp_last);
    end
    checks++;
    if (cap_busy[124] !== 1'b1 || cap_busy[125] !== 1'b0 || cap_busy[130] !== 1'b0) begin
      errors++;
      $display("FAIL busy_end: got %0b%0b%0b expected 100", cap_busy[124], cap_busy[125], cap_busy[130]);
    end
  endtask

  task automatic wait_first_read(output bit found);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (bus.o_rdEn === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset_midrun();
    bit found;
    int n_rd = 0, n_wr = 0, done_at = -1, last_wr = -1;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_first_read(found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL run2_first_read: got timeout expected o_rdEn within 12 cycles");
    end
    repeat (80) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_phase !== 3'd4 || outs_vec() !== 62'd0) begin
      errors++;
      $display("FAIL midrun_reset: got phase=%0d outs=%h expected 4/0", bus.o_phase, outs_vec());
    end
    rst = 1'b0;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_wrEn !== 1'b0) begin
      errors++;
      $display("FAIL restart_accept: got busy=%0b wr=%0b expected 1/0", bus.o_busy, bus.o_wrEn);
    end
    wait_first_read(found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL run3_first_read: got timeout expected o_rdEn within 12 cycles");
    end
    for (int c = 0; c < 130; c++) begin
      n_rd += int'(bus.o_rdEn);
      if (bus.o_wrEn === 1'b1) begin
        n_wr++;
        last_wr = c;
      end
      if (bus.o_done === 1'b1 && done_at < 0) done_at = c;
      @(negedge clk);
    end
    checks++;
    if (n_rd != 80 || n_wr != 20) begin
      errors++;
      $display("FAIL restart_counts: got rd=%0d wr=%0d expected 80/20", n_rd, n_wr);
    end
    checks++;
    if (last_wr != 124 || done_at != 125) begin
      errors++;
      $display("FAIL restart_timing: got last_wr=%0d done=%0d expected 124/125", last_wr, done_at);
    end
  endtask

  initial begin
    test_reset();
    test_start_align();
    capture_run(50);
    test_addresses();
    test_bubble();
    test_full_run();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
